// File: rtl/rf_exec_ctrl.sv
// rf_exec_ctrl: execute/writeback sequencer in front of an 8-entry register file.
module rf_exec_ctrl #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  instr,
  input  logic         instr_valid,
  output logic         instr_ready,
  output logic [2:0]   addr_srcA,
  output logic [2:0]   addr_srcB,
  output logic [2:0]   addr_dest,
  input  logic [W-1:0] srcA,
  input  logic [W-1:0] srcB,
  output logic [W-1:0] data_in,
  output logic         RF_Wen,
  output logic         WR,
  output logic         busy,
  output logic         done,
  output logic         illegal,
  output logic         flag_z,
  output logic         flag_c
);
  localparam int SHW = $clog2(W);
  typedef enum logic [2:0] {IDLE, READ, EXEC, MUL, WB} state_t;
  state_t state_q;
  logic [15:0] instr_q;
  logic [W-1:0] opa_q, opb_q, result_q;
  logic [SHW-1:0] cnt_q;
  logic ready_q, busy_q, wen_q, done_q, ill_q, z_q, c_q;
  logic [3:0] op;
  logic [W-1:0] addb_d, res_d, mac_d;
  logic [W:0] sum_d;
  logic wr_d, arith_d;
  assign op = instr_q[15:12];
  assign addr_dest = instr_q[11:9];
  assign addr_srcA = instr_q[8:6];
  assign addr_srcB = instr_q[5:3];
  assign data_in = result_q;
  assign instr_ready = ready_q;
  assign busy = busy_q;
  assign RF_Wen = wen_q;
  assign WR = wen_q;
  assign done = done_q;
  assign illegal = ill_q;
  assign flag_z = z_q;
  assign flag_c = c_q;
  // SUB runs through the adder as A + ~B + 1 so carry-out means "no borrow"
  always_comb begin
    addb_d = op == 4'h2 ? ~opb_q : op == 4'h9 ? {{(W-3){1'b0}}, instr_q[2:0]} : opb_q;
    sum_d = {1'b0, opa_q} + {1'b0, addb_d} + {{W{1'b0}}, op == 4'h2};
    arith_d = op == 4'h1 || op == 4'h2 || op == 4'h9;
    wr_d = op != 4'h0 && op <= 4'hA;
    res_d = arith_d ? sum_d[W-1:0] :
            op == 4'h3 ? opa_q & opb_q :
            op == 4'h4 ? opa_q | opb_q :
            op == 4'h5 ? opa_q ^ opb_q :
            op == 4'h6 ? opa_q << opb_q[SHW-1:0] :
            op == 4'h7 ? opa_q >> opb_q[SHW-1:0] :
            op == 4'h8 ? opa_q : '0;
    mac_d = result_q + (opb_q[0] ? opa_q : '0);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      result_q <= '0;
      cnt_q <= '0;
      ready_q <= 1'b1;
      busy_q <= 1'b0;
      wen_q <= 1'b0;
      done_q <= 1'b0;
      ill_q <= 1'b0;
      z_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      wen_q <= 1'b0;
      done_q <= 1'b0;
      ill_q <= 1'b0;
      case (state_q)
        IDLE: if (instr_valid) begin
          instr_q <= instr;
          state_q <= READ;
          ready_q <= 1'b0;
          busy_q <= 1'b1;
        end
        READ: begin
          opa_q <= srcA;
          opb_q <= srcB;
          state_q <= EXEC;
        end
        EXEC: if (op == 4'hA) begin
          result_q <= '0;
          cnt_q <= '0;
          state_q <= MUL;
        end else begin
          result_q <= res_d;
          state_q <= WB;
          wen_q <= wr_d;
          done_q <= 1'b1;
          ill_q <= op > 4'hA;
          if (wr_d) begin
            z_q <= res_d == '0;
            c_q <= arith_d & sum_d[W];
          end
        end
        // one multiplier bit per cycle: B shifts right, A shifts left
        MUL: begin
          result_q <= mac_d;
          opa_q <= opa_q << 1;
          opb_q <= opb_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == SHW'(W - 1)) begin
            state_q <= WB;
            wen_q <= 1'b1;
            done_q <= 1'b1;
            z_q <= mac_d == '0;
            c_q <= 1'b0;
          end
        end
        WB: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
